dsp_tap_delay: RTL and testbench

Multi-channel, runtime-selectable pipeline delay register for the DSP datapath. It generalises the single-stage input register with static bypass: it has DEPTH register stages, a live tap select (0 = combinational bypass, k = k-stage delay), per-stage valid tracking, synchronous clear, and an occupancy counter. It sits at operand inputs (A/B/C/D paths) and at the product output, where operand alignment needs a programmable delay.

---
 rtl/dsp_tap_delay.sv | 78 +++++++
 tb/tb_dsp_tap_delay.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/dsp_tap_delay.sv
// Multi-channel delay line: DEPTH register stages with a runtime tap select (0 = bypass, k = k-edge delay).
// Advances only on ce edges (ce low is a stall); clr takes priority and discards the input on that edge.
module dsp_tap_delay #(
  parameter int WIDTH = 18,
  parameter int CH    = 2,
  parameter int DEPTH = 4,
  parameter int TW    = $clog2(DEPTH+1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  input  logic                clr,
  input  logic [TW-1:0]       tap,
  input  logic                in_valid,
  input  logic [CH*WIDTH-1:0] in_data,
  output logic                out_valid,
  output logic [CH*WIDTH-1:0] out_data,
  output logic [TW-1:0]       occupancy,
  output logic                full
);

  localparam int DW = CH * WIDTH;

  logic [DW-1:0]  r_stage [1:DEPTH];
  logic [DEPTH:1] r_vld;
  logic [TW-1:0]  r_occ;
  logic           r_full;

  logic [TW-1:0]  w_eff_tap;
  logic [TW-1:0]  w_occ_next;
  logic [TW-1:0]  w_in_inc;
  logic [TW-1:0]  w_out_dec;

  // Occupancy counts valids entering stage 1 minus the valid leaving the last stage.
  assign w_in_inc   = {{(TW-1){1'b0}}, in_valid};
  assign w_out_dec  = {{(TW-1){1'b0}}, r_vld[DEPTH]};
  assign w_occ_next = r_occ + w_in_inc - w_out_dec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 1; k <= DEPTH; k++) r_stage[k] <= '0;
      r_vld  <= '0;
      r_occ  <= '0;
      r_full <= 1'b0;
    end else if (clr) begin
      for (int k = 1; k <= DEPTH; k++) r_stage[k] <= '0;
      r_vld  <= '0;
      r_occ  <= '0;
      r_full <= 1'b0;
    end else if (ce) begin
      r_stage[1] <= in_data;
      r_vld[1]   <= in_valid;
      for (int k = 2; k <= DEPTH; k++) begin
        r_stage[k] <= r_stage[k-1];
        r_vld[k]   <= r_vld[k-1];
      end
      r_occ  <= w_occ_next;
      r_full <= (w_occ_next == TW'(DEPTH));
    end
  end

  assign w_eff_tap = (tap > TW'(DEPTH)) ? TW'(DEPTH) : tap;

  always_comb begin
    out_data  = in_data;
    out_valid = in_valid;
    for (int k = 1; k <= DEPTH; k++) begin
      if (w_eff_tap == TW'(k)) begin
        out_data  = r_stage[k];
        out_valid = r_vld[k];
      end
    end
  end

  assign occupancy = r_occ;
  assign full      = r_full;

endmodule

// File: tb/tb_dsp_tap_delay.sv
// Directed bench for dsp_tap_delay (WIDTH=18, CH=2, DEPTH=4) with hand-computed expectations.
module tb_dsp_tap_delay;

  localparam int WIDTH = 18;
  localparam int CH    = 2;
  localparam int DEPTH = 4;
  localparam int TW    = $clog2(DEPTH+1);
  localparam int DW    = CH * WIDTH;

  logic          clk = 1'b0;
  logic          rst;
  logic          ce;
  logic          clr;
  logic [TW-1:0] tap;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [TW-1:0] occupancy;
  logic          full;

  int n_checks = 0;
  int n_errors = 0;

  dsp_tap_delay #(.WIDTH(WIDTH), .CH(CH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .clr       (clr),
    .tap       (tap),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .occupancy (occupancy),
    .full      (full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Channel 1 carries a distinct value so slice swaps are caught.
  function automatic logic [DW-1:0] mk(input int v);
    logic [WIDTH-1:0] c0;
    logic [WIDTH-1:0] c1;
    c0 = WIDTH'(v);
    c1 = WIDTH'(v + 1000);
    return {c1, c0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    ce  = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; clr = 1'b0; tap = '0; in_valid = 1'b0; in_data = '0;
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_occ", 64'(occupancy), 64'd0);
    check("rst_full", 64'(full), 64'd0);
    rst = 1'b0;
    tick();

    // Latency sweep; tap 7 must clamp to 4.
    for (int t = 0; t <= 7; t++) begin
      int e;
      if (t == 5 || t == 6) continue;
      e = (t > DEPTH) ? DEPTH : t;
      do_clr();
      tap = TW'(t);
      ce  = 1'b1;
      for (int i = 0; i < 8; i++) begin
        in_data  = mk(100 * t + i);
        in_valid = 1'b1;
        #1;
        if (i >= e) begin
          check($sformatf("lat_t%0d_i%0d_dat", t, i), 64'(out_data), 64'(mk(100 * t + i - e)));
          check($sformatf("lat_t%0d_i%0d_vld", t, i), 64'(out_valid), 64'd1);
        end else begin
          check($sformatf("lat_t%0d_i%0d_vld", t, i), 64'(out_valid), 64'd0);
        end
        tick();
      end
    end

    // Async reset mid-stream with a full pipeline, no edge needed.
    tap = TW'(2);
    #2;
    rst = 1'b1;
    #1;
    check("arst_dat", 64'(out_data), 64'd0);
    check("arst_vld", 64'(out_valid), 64'd0);
    check("arst_occ", 64'(occupancy), 64'd0);
    check("arst_full", 64'(full), 64'd0);
    rst = 1'b0;
    tick();

    // Stall: ce pattern 1,0,0,1,1 moves the sample exactly three stages.
    do_clr();
    tap = TW'(3);
    in_data = mk(50); in_valid = 1'b1; ce = 1'b1;
    tick();
    in_data = '0; in_valid = 1'b0;
    #1;
    check("stall_e1_tap3_vld", 64'(out_valid), 64'd0);
    tap = TW'(1);
    #1;
    check("stall_e1_tap1_dat", 64'(out_data), 64'(mk(50)));
    check("stall_e1_occ", 64'(occupancy), 64'd1);
    ce = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("stall_hold%0d_dat", i), 64'(out_data), 64'(mk(50)));
      check($sformatf("stall_hold%0d_occ", i), 64'(occupancy), 64'd1);
    end
    ce = 1'b1;
    tick();
    tap = TW'(2);
    #1;
    check("stall_e4_tap2_dat", 64'(out_data), 64'(mk(50)));
    tick();
    tap = TW'(3);
    #1;
    check("stall_e5_tap3_dat", 64'(out_data), 64'(mk(50)));
    check("stall_e5_tap3_vld", 64'(out_valid), 64'd1);

    // Fill then drain.
    do_clr();
    ce = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      int exp_occ;
      in_valid = (i <= 5);
      in_data  = mk(200 + i);
      tick();
      exp_occ = (i <= 4) ? i : (i == 5) ? 4 : 9 - i;
      check($sformatf("fill_e%0d_occ", i), 64'(occupancy), 64'(exp_occ));
      check($sformatf("fill_e%0d_full", i), 64'(full), 64'(exp_occ == 4));
    end

    // Refill, then clr collides with ce and a valid 0xAA sample.
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = mk(300 + i);
      tick();
    end
    check("coll_pre_full", 64'(full), 64'd1);
    clr = 1'b1; ce = 1'b1; in_valid = 1'b1; in_data = mk(32'hAA);
    tick();
    clr = 1'b0; ce = 1'b0; in_valid = 1'b0; in_data = '0;
    #1;
    check("coll_occ", 64'(occupancy), 64'd0);
    check("coll_full", 64'(full), 64'd0);
    for (int t = 1; t <= DEPTH; t++) begin
      tap = TW'(t);
      #1;
      check($sformatf("coll_t%0d_vld", t), 64'(out_valid), 64'd0);
      check($sformatf("coll_t%0d_dat", t), 64'(out_data), 64'd0);
    end

    // Live tap switch 1 -> 3: output steps back two samples in the same cycle.
    do_clr();
    tap = TW'(1);
    ce = 1'b1; in_valid = 1'b1;
    for (int i = 0; i <= 15; i++) begin
      in_data = mk(10 + i);
      #1;
      if (i >= 4 && i <= 11) check($sformatf("sw_t1_i%0d", i), 64'(out_data), 64'(mk(9 + i)));
      if (i == 11) begin
        tap = TW'(3);
        #1;
        check("sw_jump", 64'(out_data), 64'(mk(18)));
      end
      if (i >= 12) check($sformatf("sw_t3_i%0d", i), 64'(out_data), 64'(mk(7 + i)));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
